// File: rtl/csr_dmw_regs.sv
// LoongArch DMW0/DMW1 CSR storage with read port, valid/ready write port and post-write settle window.
// Optional: define CSR_DMW_XCHG_EN to honour wr_mask (csrxchg); otherwise writes are full-width.
module csr_dmw_regs #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [13:0] DMW0_ADDR     = 14'h180,
    parameter logic [13:0] DMW1_ADDR     = 14'h181
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] csr_rd_addr,
    output logic [31:0] csr_rd_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [13:0] wr_addr,
    input  logic [31:0] wr_data,
    input  logic [31:0] wr_mask,
    output logic        dmw0_plv0,
    output logic        dmw0_plv3,
    output logic [1:0]  dmw0_mat,
    output logic [2:0]  dmw0_pseg,
    output logic [2:0]  dmw0_vseg,
    output logic        dmw1_plv0,
    output logic        dmw1_plv3,
    output logic [1:0]  dmw1_mat,
    output logic [2:0]  dmw1_pseg,
    output logic [2:0]  dmw1_vseg,
    output logic        dmw_stable,
    output logic        dmw_changed
);

    // Bits 31:29, 27:25, 5:4, 3 and 0 are the only implemented fields.
    localparam logic [31:0] IMPL_MASK   = 32'hEE00_0039;
    localparam logic [0:0]  StIdle      = 1'b0;
    localparam logic [0:0]  StSettle    = 1'b1;
    localparam logic [3:0]  SETTLE_INIT = 4'(SETTLE_CYCLES);

    logic [31:0] dmw0_q, dmw0_d;
    logic [31:0] dmw1_q, dmw1_d;
    logic [0:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        changed_q, changed_d;
    logic        wr_fire;
    logic        hit0, hit1;
    logic [31:0] eff_mask;

`ifdef CSR_DMW_XCHG_EN
    assign eff_mask = wr_mask;
`else
    logic unused_wr_mask;
    assign unused_wr_mask = ^wr_mask;
    assign eff_mask       = '1;
`endif

    assign wr_ready = (state_q == StIdle);
    assign wr_fire  = wr_valid & wr_ready;
    assign hit0     = (wr_addr == DMW0_ADDR);
    assign hit1     = (wr_addr == DMW1_ADDR);

    always_comb begin
        dmw0_d    = dmw0_q;
        dmw1_d    = dmw1_q;
        changed_d = wr_fire & (hit0 | hit1);
        if (wr_fire && hit0) begin
            dmw0_d = ((dmw0_q & ~eff_mask) | (wr_data & eff_mask)) & IMPL_MASK;
        end
        if (wr_fire && hit1) begin
            dmw1_d = ((dmw1_q & ~eff_mask) | (wr_data & eff_mask)) & IMPL_MASK;
        end
    end

    // A zero-length settle keeps the FSM in idle so writes can go back-to-back.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (changed_d && (SETTLE_CYCLES != 0)) begin
                    state_d = StSettle;
                    cnt_d   = SETTLE_INIT;
                end
            end
            StSettle: begin
                if (cnt_q <= 4'd1) begin
                    state_d = StIdle;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dmw0_q    <= 32'd0;
            dmw1_q    <= 32'd0;
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            changed_q <= 1'b0;
        end else begin
            dmw0_q    <= dmw0_d;
            dmw1_q    <= dmw1_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            changed_q <= changed_d;
        end
    end

    always_comb begin
        csr_rd_data = 32'd0;
        if (csr_rd_addr == DMW0_ADDR) begin
            csr_rd_data = dmw0_q;
        end else if (csr_rd_addr == DMW1_ADDR) begin
            csr_rd_data = dmw1_q;
        end
    end

    assign dmw_stable  = (state_q == StIdle);
    assign dmw_changed = changed_q;

    assign dmw0_plv0 = dmw0_q[0];
    assign dmw0_plv3 = dmw0_q[3];
    assign dmw0_mat  = dmw0_q[5:4];
    assign dmw0_pseg = dmw0_q[27:25];
    assign dmw0_vseg = dmw0_q[31:29];
    assign dmw1_plv0 = dmw1_q[0];
    assign dmw1_plv3 = dmw1_q[3];
    assign dmw1_mat  = dmw1_q[5:4];
    assign dmw1_pseg = dmw1_q[27:25];
    assign dmw1_vseg = dmw1_q[31:29];

endmodule
